// File: rtl/md_unit_pkg.sv
// Shared encodings and default latencies for the multiply/divide unit.
package md_unit_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_e;

    localparam int MD_MULT_CYCLES = 5;
    localparam int MD_DIV_CYCLES  = 10;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } md_res_t;

endpackage

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO. Results are computed at
// issue and parked in pend_hi/pend_lo; a down-counter models the latency
// and commits them to HI/LO on its final tick.
module md_unit
    import md_unit_pkg::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [2:0]  MDOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    logic [3:0]  cnt;
    logic [31:0] pend_hi, pend_lo;

    logic        signed_op, neg_a, neg_b;
    logic [63:0] a_ext, b_ext, prod;
    logic [31:0] a_mag, b_mag, div_b, q_mag, r_mag;
    md_res_t     div_res;

    assign Busy = (cnt != 4'd0);

    // Behavioural product and sign-magnitude quotient/remainder for the
    // current operands; magnitude division sidesteps the signed overflow
    // case (0x80000000 / -1) and truncates toward zero naturally.
    always_comb begin
        signed_op = (MDOp == MD_MULT) || (MDOp == MD_DIV);
        neg_a     = signed_op & A[31];
        neg_b     = signed_op & B[31];
        a_ext     = {{32{neg_a}}, A};
        b_ext     = {{32{neg_b}}, B};
        prod      = a_ext * b_ext;
        a_mag     = neg_a ? (~A + 32'd1) : A;
        b_mag     = neg_b ? (~B + 32'd1) : B;
        div_b     = (b_mag == 32'd0) ? 32'd1 : b_mag;
        q_mag     = a_mag / div_b;
        r_mag     = a_mag % div_b;
        if (B == 32'd0) begin
            div_res.lo = 32'hFFFF_FFFF;
            div_res.hi = A;
        end else begin
            div_res.lo = (neg_a ^ neg_b) ? (~q_mag + 32'd1) : q_mag;
            div_res.hi = neg_a ? (~r_mag + 32'd1) : r_mag;
        end
    end

    // Issue, countdown and commit; a start while busy is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            HI      <= '0;
            LO      <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            cnt     <= '0;
        end else if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) begin
                HI <= pend_hi;
                LO <= pend_lo;
            end
        end else if (Start) begin
            case (MDOp)
                MD_MULT, MD_MULTU: begin
                    pend_hi <= prod[63:32];
                    pend_lo <= prod[31:0];
                    cnt     <= 4'(MULT_CYCLES);
                end
                MD_DIV, MD_DIVU: begin
                    pend_hi <= div_res.hi;
                    pend_lo <= div_res.lo;
                    cnt     <= 4'(DIV_CYCLES);
                end
                MD_MTHI: HI <= A;
                MD_MTLO: LO <= A;
                default: ;
            endcase
        end
    end

endmodule
